mem_stage: RTL

//  Memory-access stage of the 5-stage pipeline, directly downstream of the EX/MEM register.
//  - Issues loads/stores to the data-memory port with a req/ack handshake.
//  - Aligns, sign/zero-extends load data and builds store byte enables.
//  - Stalls upstream while memory is busy; registers results into the MEM/WB boundary.

---
 rtl/mem_stage_pkg.sv | 39 +++
 rtl/mem_stage_if.sv | 23 ++
 rtl/mem_load_align.sv | 28 ++
 rtl/mem_stage.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage:
// opcode constants, FSM states and access-size decoding.
package mem_stage_pkg;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW  = 6'h2b;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  function automatic size_t op_size(logic [5:0] op);
    size_t s;
    s = SZ_B;
    unique case (1'b1)
      op == OP_LW,
      op == OP_SW:  s = SZ_W;
      op == OP_LH,
      op == OP_LHU,
      op == OP_SH:  s = SZ_H;
      default:      s = SZ_B;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port: req/ack handshake between the
// memory stage (master) and data memory (slave).
interface mem_stage_if #(
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        be;
  logic [31:0]       rdata;
  logic              ack;

  modport master (
    output req, we, addr, wdata, be,
    input  rdata, ack
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output rdata, ack
  );
endinterface

// File: rtl/mem_load_align.sv
// Load alignment: picks the addressed lane of the
// read word and sign/zero-extends it by opcode.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [5:0]  opcode,
  output logic [31:0] result
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b      = rdata[{off, 3'b000} +: 8];
    h      = off[1] ? rdata[31:16] : rdata[15:0];
    result = rdata;
    unique case (1'b1)
      opcode == OP_LB:  result = {{24{b[7]}}, b};
      opcode == OP_LBU: result = {24'd0, b};
      opcode == OP_LH:  result = {{16{h[15]}}, h};
      opcode == OP_LHU: result = {16'd0, h};
      default:          result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues dmem accesses, stalls
// upstream while busy and registers MEM/WB results.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WAIT_LIMIT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] alu_result_in,
  input  logic [5:0]        opcode_in,
  input  logic [4:0]        rd_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [31:0]       rd_data_in,
  input  logic              reg_write_in,
  mem_stage_if.master       dmem,
  output logic              stall_out,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              wb_reg_write,
  output logic              mem_err
);

  state_t      state, state_n;
  size_t       sz;
  logic [15:0] wcnt;
  logic [1:0]  off;
  logic        is_mem, is_ld, is_st;
  logic        misal, go, limit_hit;
  logic        stall, tmo;
  logic [31:0] ld_res;
  logic [4:0]  nxt_rd;
  logic [31:0] nxt_data;
  logic        nxt_rw, nxt_err;

  assign sz     = op_size(opcode_in);
  assign off    = alu_result_in[1:0];
  assign is_mem = mem_read_in | mem_write_in;
  assign is_ld  = mem_read_in;
  assign is_st  = mem_write_in & ~mem_read_in;
  assign misal  = is_mem &
                  ((sz == SZ_H && off[0]) ||
                   (sz == SZ_W && off != 2'b00));
  assign go     = is_mem & ~misal;

  assign limit_hit = (WAIT_LIMIT != 0) &&
                     (wcnt == 16'(WAIT_LIMIT - 1));

  // Reset must silence the bus at once, even mid-cycle
  assign dmem.req  = go & ~reset;
  assign stall_out = stall & ~reset;
  assign dmem.we   = is_st;
  assign dmem.addr = {alu_result_in[ADDR_W-1:2], 2'b00};

  always_comb begin
    dmem.be    = 4'b1111;
    dmem.wdata = rd_data_in;
    if (is_st) begin
      unique case (1'b1)
        sz == SZ_B: begin
          dmem.be    = 4'b0001 << off;
          dmem.wdata = {4{rd_data_in[7:0]}};
        end
        sz == SZ_H: begin
          dmem.be    = off[1] ? 4'b1100 : 4'b0011;
          dmem.wdata = {2{rd_data_in[15:0]}};
        end
        default: dmem.be = 4'b1111;
      endcase
    end
  end

  mem_load_align u_align (
    .rdata  (dmem.rdata),
    .off    (off),
    .opcode (opcode_in),
    .result (ld_res)
  );

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      IDLE: begin
        if (go && !dmem.ack) begin
          if (limit_hit) begin
            tmo = 1'b1;
          end else begin
            stall   = 1'b1;
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (!go || dmem.ack) begin
          state_n = IDLE;
        end else if (limit_hit) begin
          tmo     = 1'b1;
          state_n = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    nxt_rd   = 5'd0;
    nxt_data = 32'd0;
    nxt_rw   = 1'b0;
    nxt_err  = 1'b0;
    if (stall) begin
      nxt_err = 1'b0;
    end else if (misal || tmo) begin
      nxt_err = 1'b1;
    end else begin
      nxt_rd   = rd_in;
      nxt_rw   = reg_write_in;
      nxt_data = is_ld ? ld_res : alu_result_in[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= stall ? wcnt + 16'd1 : '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_rd        <= '0;
      wb_data      <= '0;
      wb_reg_write <= 1'b0;
      mem_err      <= 1'b0;
    end else begin
      wb_rd        <= nxt_rd;
      wb_data      <= nxt_data;
      wb_reg_write <= nxt_rw;
      mem_err      <= nxt_err;
    end
  end

endmodule
